mpi_sram_ctrl: RTL

//  Responder for the MPI SRAM command path. Consumes the start/cmd/addr/data

---
 rtl/mpi_sram_ctrl_pkg.sv | 24 ++
 rtl/mpi_sram_ctrl_if.sv | 25 ++
 rtl/mpi_sram_ctrl_sync_2ff.sv | 20 ++
 rtl/mpi_sram_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mpi_sram_ctrl_pkg.sv
// Shared definitions for the MPI SRAM command path: FSM states, command
// encoding and default chip timing.
package mem_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT,
        ST_HOLD
    } state_e;

    localparam logic CMD_RD = 1'b1;
    localparam logic CMD_WR = 1'b0;

    localparam int unsigned T_SETUP_DEF  = 2;
    localparam int unsigned T_ACC_DEF    = 4;
    localparam int unsigned T_HOLD_DEF   = 1;
    localparam int unsigned WAIT_TMO_DEF = 255;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 32;

endpackage

// File: rtl/mpi_sram_ctrl_if.sv
// Command/response bus between the MPI register block (master) and the
// SRAM controller (slave).
interface mpi_sram_ctrl_if;
    import mem_if_pkg::*;

    logic          mpi_sram_start;
    logic          mpi_sram_cmd;
    logic [AW-1:0] mpi_sram_addr;
    logic [DW-1:0] mpi_sram_data_wr;
    logic [DW-1:0] mpi_sram_data_rd;
    logic          mpi_sram_done;
    logic          mpi_sram_waitn;
    logic          mpi_sram_tmo;

    modport master (
        output mpi_sram_start, mpi_sram_cmd, mpi_sram_addr, mpi_sram_data_wr,
        input  mpi_sram_data_rd, mpi_sram_done, mpi_sram_waitn, mpi_sram_tmo
    );

    modport slave (
        input  mpi_sram_start, mpi_sram_cmd, mpi_sram_addr, mpi_sram_data_wr,
        output mpi_sram_data_rd, mpi_sram_done, mpi_sram_waitn, mpi_sram_tmo
    );

endinterface

// File: rtl/mpi_sram_ctrl_sync_2ff.sv
// Two-flop synchroniser with a configurable reset (preset) value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= {2{RST_VAL}};
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/mpi_sram_ctrl.sv
// Runs one async SRAM read or write cycle per rising edge of mpi_sram_start,
// with chip-wait stretching and timeout.
module mpi_sram_ctrl
    import mem_if_pkg::*;
#(
    parameter int unsigned T_SETUP  = T_SETUP_DEF,
    parameter int unsigned T_ACC    = T_ACC_DEF,
    parameter int unsigned T_HOLD   = T_HOLD_DEF,
    parameter int unsigned WAIT_TMO = WAIT_TMO_DEF
) (
    input  logic          clk_mpi,
    input  logic          rst_mpi,
    mpi_sram_ctrl_if.slave mpi,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [DW-1:0] sram_dq_i,
    output logic          sram_cen,
    output logic          sram_oen,
    output logic          sram_wen,
    output logic [3:0]    sram_ben,
    input  logic          sram_wait_pin
);

    localparam logic [7:0] SETUP_LAST = 8'(T_SETUP - 1);
    localparam logic [7:0] ACC_LAST   = 8'(T_ACC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(T_HOLD - 1);
    localparam logic [7:0] TMO_CNT    = 8'(WAIT_TMO);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          start_dly_q;
    logic          is_rd_q, is_rd_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] dq_o_q, dq_o_d;
    logic [DW-1:0] data_rd_q, data_rd_d;
    logic          dq_oe_q, dq_oe_d;
    logic          cen_q, cen_d, oen_q, oen_d, wen_q, wen_d;
    logic [3:0]    ben_q, ben_d;
    logic          done_q, done_d, tmo_q, tmo_d;
    logic          waitn_sync, start_edge, finish;

    sync_2ff #(.RST_VAL(1'b1)) u_wait_sync (
        .clk_i (clk_mpi),
        .rst_i (rst_mpi),
        .d_i   (sram_wait_pin),
        .q_o   (waitn_sync)
    );

    assign start_edge = mpi.mpi_sram_start & ~start_dly_q;

    always_ff @(posedge clk_mpi or posedge rst_mpi) begin
        if (rst_mpi) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            start_dly_q <= 1'b0;
            is_rd_q     <= 1'b0;
            a_q         <= '0;
            dq_o_q      <= '0;
            data_rd_q   <= '0;
            dq_oe_q     <= 1'b0;
            cen_q       <= 1'b1;
            oen_q       <= 1'b1;
            wen_q       <= 1'b1;
            ben_q       <= '1;
            done_q      <= 1'b1;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_dly_q <= mpi.mpi_sram_start;
            is_rd_q     <= is_rd_d;
            a_q         <= a_d;
            dq_o_q      <= dq_o_d;
            data_rd_q   <= data_rd_d;
            dq_oe_q     <= dq_oe_d;
            cen_q       <= cen_d;
            oen_q       <= oen_d;
            wen_q       <= wen_d;
            ben_q       <= ben_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        is_rd_d   = is_rd_q;
        a_d       = a_q;
        dq_o_d    = dq_o_q;
        data_rd_d = data_rd_q;
        dq_oe_d   = dq_oe_q;
        cen_d     = cen_q;
        oen_d     = oen_q;
        wen_d     = wen_q;
        ben_d     = ben_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        finish    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    is_rd_d = (mpi.mpi_sram_cmd == CMD_RD);
                    a_d     = mpi.mpi_sram_addr;
                    cen_d   = 1'b0;
                    ben_d   = '0;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                    if (mpi.mpi_sram_cmd != CMD_RD) begin
                        dq_oe_d = 1'b1;
                        dq_o_d  = mpi.mpi_sram_data_wr;
                    end
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    if (is_rd_q) oen_d = 1'b0;
                    else         wen_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == ACC_LAST) begin
                    if (!waitn_sync) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (waitn_sync) begin
                    finish = 1'b1;
                end else if (cnt_q == TMO_CNT) begin
                    finish = 1'b1;
                    tmo_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cen_d   = 1'b1;
                    ben_d   = '1;
                    dq_oe_d = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read data is captured on the same edge that releases the strobe.
        if (finish) begin
            if (is_rd_q) data_rd_d = sram_dq_i;
            oen_d   = 1'b1;
            wen_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_HOLD;
        end
    end

    assign sram_a               = a_q;
    assign sram_dq_o            = dq_o_q;
    assign sram_dq_oe           = dq_oe_q;
    assign sram_cen             = cen_q;
    assign sram_oen             = oen_q;
    assign sram_wen             = wen_q;
    assign sram_ben             = ben_q;
    assign mpi.mpi_sram_data_rd = data_rd_q;
    assign mpi.mpi_sram_done    = done_q;
    assign mpi.mpi_sram_waitn   = waitn_sync;
    assign mpi.mpi_sram_tmo     = tmo_q;

endmodule
